multi_cycle_ctrl_fsm: RTL and testbench

//  Next-gen control FSM for the multicycle MIPS core. Decodes op_code/funct from the IR, sequences

---
 rtl/multi_cycle_ctrl_fsm_if.sv | 48 ++++
 rtl/multi_cycle_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl_fsm.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// Carries instruction fields and memory status in, and mux selects/enables out.
// The master modport is the controller; the slave modport is the datapath side.
interface multi_cycle_ctrl_fsm_if #(
    parameter int ALU_W = 3
) ();
    // Instruction fields and memory/fetch status
    logic [5:0]       op_code;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             stall;

    // Datapath controls
    logic             pc_write;
    logic             branch_eq;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic [ALU_W-1:0] alu_cntrl;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             imm_zext;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             ir_write;
    logic             mem_write;
    logic             i_or_d;
    logic             mem_req;

    // Status / debug
    logic             illegal_op;
    logic             mem_timeout;
    logic [3:0]       state_o;

    modport master (
        input  op_code, funct, mem_ready, stall,
        output pc_write, branch_eq, branch_ne, pc_src, alu_cntrl, alu_src_a, alu_src_b,
               imm_zext, reg_write, mem_to_reg, reg_dst, ir_write, mem_write, i_or_d,
               mem_req, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output op_code, funct, mem_ready, stall,
        input  pc_write, branch_eq, branch_ne, pc_src, alu_cntrl, alu_src_a, alu_src_b,
               imm_zext, reg_write, mem_to_reg, reg_dst, ir_write, mem_write, i_or_d,
               mem_req, illegal_op, mem_timeout, state_o
    );
endinterface

// File: rtl/multi_cycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences FETCH..WRITEBACK and drives datapath selects/enables.
// Latency (no memory wait): R/ADDI/ANDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles; outputs are same-cycle.
// Memory states hold until mem_ready (bounded by TIMEOUT, then trap); stall holds FETCH with no request.
module multi_cycle_ctrl_fsm #(
    parameter int ALU_W    = 3,
    parameter int MEM_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_cycle_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWRBK = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWRBK = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWRBK = 4'd10,
        S_JMP     = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // Last wait count before the trap fires (the TIMEOUT-th waiting cycle).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    // Decoded helpers
    logic [2:0] r_alu;
    logic       r_ok;
    logic [2:0] imm_alu;
    logic       imm_zx;
    logic       mem_done;
    logic       req_active;

    // Unqualified (pre-reset-gating) control outputs
    logic       pc_write_c, branch_eq_c, branch_ne_c;
    logic [1:0] pc_src_c;
    logic [2:0] alu_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic       imm_zext_c, reg_write_c, mem_to_reg_c, reg_dst_c;
    logic       ir_write_c, mem_write_c, i_or_d_c, mem_req_c;

    // Instruction field decode: R-type funct to ALU op, immediate opcode to ALU op/extension
    always_comb begin
        r_alu   = ALU_AND;
        r_ok    = 1'b1;
        imm_alu = ALU_ADD;
        imm_zx  = 1'b0;
        case (bus.funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b101010: r_alu = ALU_SLT;
            6'b000000: r_alu = ALU_SLL;
            6'b000010: r_alu = ALU_SRL;
            default:   r_ok  = 1'b0;
        endcase
        case (bus.op_code)
            OP_ANDI: begin imm_alu = ALU_AND; imm_zx = 1'b1; end
            OP_ORI:  begin imm_alu = ALU_OR;  imm_zx = 1'b1; end
            default: begin imm_alu = ALU_ADD; imm_zx = 1'b0; end
        endcase
    end

    // A memory access completes this cycle when ready is seen, or always if waits are disabled
    assign mem_done   = (MEM_WAIT == 0) || bus.mem_ready;
    assign req_active = (state_q == S_MEMREAD) || (state_q == S_MEMWR) ||
                        ((state_q == S_FETCH) && !bus.stall);

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state, wait counter and trap causes
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_FETCH:   if (!bus.stall && mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op_code)
                    OP_R:                      state_d = S_EXEC;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
                    OP_J:                      state_d = S_JMP;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (bus.op_code == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: if (mem_done) state_d = S_MEMWRBK;
            S_MEMWRBK: state_d = S_FETCH;
            S_MEMWR:   if (mem_done) state_d = S_FETCH;
            S_EXEC: begin
                if (r_ok) begin
                    state_d = S_ALUWRBK;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_ALUWRBK: state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_IMMEX:   state_d = S_IMMWRBK;
            S_IMMWRBK: state_d = S_FETCH;
            S_JMP:     state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_TRAP;
        endcase

        // Count cycles spent waiting on memory; a completing access never times out
        if (req_active && !mem_done) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_q == WAIT_LAST) begin
                state_d   = S_TRAP;
                timeout_d = 1'b1;
            end
        end

        // Every state change starts the next memory state with a fresh count
        if (state_d != state_q) wait_cnt_d = 8'd0;
    end

    // Moore controls per state, with fetch/memory qualifiers from stall and ready
    always_comb begin
        pc_write_c   = 1'b0;
        branch_eq_c  = 1'b0;
        branch_ne_c  = 1'b0;
        pc_src_c     = 2'b00;
        alu_c        = ALU_AND;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        imm_zext_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_dst_c    = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        i_or_d_c     = 1'b0;
        mem_req_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!bus.stall) begin
                    mem_req_c   = 1'b1;
                    alu_src_b_c = 2'b01;
                    alu_c       = ALU_ADD;
                    ir_write_c  = mem_done;
                    pc_write_c  = mem_done;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                alu_c       = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_c       = ALU_ADD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
            end
            S_MEMWRBK: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_c       = r_alu;
            end
            S_ALUWRBK: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_c       = ALU_SUB;
                pc_src_c    = 2'b01;
                branch_eq_c = (bus.op_code == OP_BEQ);
                branch_ne_c = (bus.op_code == OP_BNE);
            end
            S_IMMEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_c       = imm_alu;
                imm_zext_c  = imm_zx;
            end
            S_IMMWRBK: begin
                reg_write_c = 1'b1;
                alu_c       = imm_alu;
                imm_zext_c  = imm_zx;
            end
            S_JMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'b10;
            end
            default: ;
        endcase
    end

    // Reset forces every output low combinationally, so nothing fires while rst is asserted
    assign bus.pc_write    = rst & pc_write_c;
    assign bus.branch_eq   = rst & branch_eq_c;
    assign bus.branch_ne   = rst & branch_ne_c;
    assign bus.pc_src      = rst ? pc_src_c : 2'b00;
    assign bus.alu_cntrl   = rst ? ALU_W'(alu_c) : '0;
    assign bus.alu_src_a   = rst & alu_src_a_c;
    assign bus.alu_src_b   = rst ? alu_src_b_c : 2'b00;
    assign bus.imm_zext    = rst & imm_zext_c;
    assign bus.reg_write   = rst & reg_write_c;
    assign bus.mem_to_reg  = rst & mem_to_reg_c;
    assign bus.reg_dst     = rst & reg_dst_c;
    assign bus.ir_write    = rst & ir_write_c;
    assign bus.mem_write   = rst & mem_write_c;
    assign bus.i_or_d      = rst & i_or_d_c;
    assign bus.mem_req     = rst & mem_req_c;
    assign bus.illegal_op  = rst & illegal_q;
    assign bus.mem_timeout = rst & timeout_q;
    assign bus.state_o     = rst ? state_q : S_FETCH;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Directed bench for the multicycle control FSM.
// Two instances: waits enabled with TIMEOUT=4, and waits disabled (mem_ready tied low).
// Every output is compared each step against hand-built per-state expectations.
module tb_multi_cycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, beq, bne;
        logic [1:0] pcs;
        logic [2:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       zx, rw, m2r, rd, irw, mw, iod, req, ill, tmo;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b1;
    logic       stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl_fsm_if #(.ALU_W(3)) bus1 ();
    multi_cycle_ctrl_fsm_if #(.ALU_W(3)) bus0 ();

    assign bus1.op_code   = op_code;
    assign bus1.funct     = funct;
    assign bus1.mem_ready = mem_ready;
    assign bus1.stall     = stall;
    assign bus0.op_code   = op_code;
    assign bus0.funct     = funct;
    assign bus0.mem_ready = 1'b0;
    assign bus0.stall     = stall;

    multi_cycle_ctrl_fsm #(.ALU_W(3), .MEM_WAIT(1), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    multi_cycle_ctrl_fsm #(.ALU_W(3), .MEM_WAIT(0), .TIMEOUT(255)) dut_nowait (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    obs_t o1, o0;
    assign o1 = {bus1.state_o, bus1.pc_write, bus1.branch_eq, bus1.branch_ne, bus1.pc_src,
                 bus1.alu_cntrl, bus1.alu_src_a, bus1.alu_src_b, bus1.imm_zext, bus1.reg_write,
                 bus1.mem_to_reg, bus1.reg_dst, bus1.ir_write, bus1.mem_write, bus1.i_or_d,
                 bus1.mem_req, bus1.illegal_op, bus1.mem_timeout};
    assign o0 = {bus0.state_o, bus0.pc_write, bus0.branch_eq, bus0.branch_ne, bus0.pc_src,
                 bus0.alu_cntrl, bus0.alu_src_a, bus0.alu_src_b, bus0.imm_zext, bus0.reg_write,
                 bus0.mem_to_reg, bus0.reg_dst, bus0.ir_write, bus0.mem_write, bus0.i_or_d,
                 bus0.mem_req, bus0.illegal_op, bus0.mem_timeout};

    // Expected output vectors, one constructor per state
    function automatic obs_t e_zero();
        obs_t o = '0;
        return o;
    endfunction
    function automatic obs_t e_fetch(input logic rdy);
        obs_t o = '0;
        o.st = 4'd0; o.req = 1'b1; o.sb = 2'b01; o.alu = 3'b010; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction
    function automatic obs_t e_decode();
        obs_t o = '0;
        o.st = 4'd1; o.sb = 2'b11; o.alu = 3'b010;
        return o;
    endfunction
    function automatic obs_t e_memadr();
        obs_t o = '0;
        o.st = 4'd2; o.sa = 1'b1; o.sb = 2'b10; o.alu = 3'b010;
        return o;
    endfunction
    function automatic obs_t e_memread();
        obs_t o = '0;
        o.st = 4'd3; o.req = 1'b1; o.iod = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_memwrbk();
        obs_t o = '0;
        o.st = 4'd4; o.rw = 1'b1; o.m2r = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_memwr();
        obs_t o = '0;
        o.st = 4'd5; o.req = 1'b1; o.mw = 1'b1; o.iod = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_exec(input logic [2:0] alu);
        obs_t o = '0;
        o.st = 4'd6; o.sa = 1'b1; o.alu = alu;
        return o;
    endfunction
    function automatic obs_t e_aluwrbk();
        obs_t o = '0;
        o.st = 4'd7; o.rw = 1'b1; o.rd = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_branch(input logic eq);
        obs_t o = '0;
        o.st = 4'd8; o.sa = 1'b1; o.alu = 3'b110; o.pcs = 2'b01; o.beq = eq; o.bne = !eq;
        return o;
    endfunction
    function automatic obs_t e_immex(input logic [2:0] alu, input logic zx);
        obs_t o = '0;
        o.st = 4'd9; o.sa = 1'b1; o.sb = 2'b10; o.alu = alu; o.zx = zx;
        return o;
    endfunction
    function automatic obs_t e_immwrbk(input logic [2:0] alu, input logic zx);
        obs_t o = '0;
        o.st = 4'd10; o.rw = 1'b1; o.alu = alu; o.zx = zx;
        return o;
    endfunction
    function automatic obs_t e_jmp();
        obs_t o = '0;
        o.st = 4'd11; o.pcw = 1'b1; o.pcs = 2'b10;
        return o;
    endfunction
    function automatic obs_t e_trap(input logic ill, input logic tmo);
        obs_t o = '0;
        o.st = 4'd12; o.ill = ill; o.tmo = tmo;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change here, checks follow #1 later
    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held: every output low on both instances
        #12;
        chk("reset_outputs", 32'(o1), 32'(e_zero()));
        chk("reset_outputs_nowait", 32'(o0), 32'(e_zero()));

        // ADD on both instances: 0,1,6,7,0 (no-wait instance ignores its low mem_ready)
        op_code = 6'b000000; funct = 6'b100000; rst = 1'b1;
        #1; chk("add_fetch", 32'(o1), 32'(e_fetch(1'b1)));
        chk("add_fetch_nowait", 32'(o0), 32'(e_fetch(1'b1)));
        adv(); #1; chk("add_decode", 32'(o1), 32'(e_decode()));
        chk("add_decode_nowait", 32'(o0), 32'(e_decode()));
        adv(); #1; chk("add_exec", 32'(o1), 32'(e_exec(3'b010)));
        chk("add_exec_nowait", 32'(o0), 32'(e_exec(3'b010)));
        adv(); #1; chk("add_aluwrbk", 32'(o1), 32'(e_aluwrbk()));
        chk("add_aluwrbk_nowait", 32'(o0), 32'(e_aluwrbk()));
        adv(); #1; chk("add_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));
        chk("add_back_fetch_nowait", 32'(o0), 32'(e_fetch(1'b1)));

        // LW with three not-ready cycles in FETCH and in MEMREAD
        op_code = 6'b100011; mem_ready = 1'b0;
        #1; chk("lw_fetch_wait1", 32'(o1), 32'(e_fetch(1'b0)));
        adv(); #1; chk("lw_fetch_wait2", 32'(o1), 32'(e_fetch(1'b0)));
        adv(); #1; chk("lw_fetch_wait3", 32'(o1), 32'(e_fetch(1'b0)));
        adv(); mem_ready = 1'b1;
        #1; chk("lw_fetch_ready", 32'(o1), 32'(e_fetch(1'b1)));
        adv(); #1; chk("lw_decode", 32'(o1), 32'(e_decode()));
        adv(); #1; chk("lw_memadr", 32'(o1), 32'(e_memadr()));
        adv(); mem_ready = 1'b0;
        #1; chk("lw_memread_wait1", 32'(o1), 32'(e_memread()));
        adv(); #1; chk("lw_memread_wait2", 32'(o1), 32'(e_memread()));
        adv(); #1; chk("lw_memread_wait3", 32'(o1), 32'(e_memread()));
        adv(); mem_ready = 1'b1;
        #1; chk("lw_memread_ready", 32'(o1), 32'(e_memread()));
        adv(); #1; chk("lw_memwrbk", 32'(o1), 32'(e_memwrbk()));
        adv(); #1; chk("lw_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // BNE
        op_code = 6'b000101;
        adv(); #1; chk("bne_decode", 32'(o1), 32'(e_decode()));
        adv(); #1; chk("bne_branch", 32'(o1), 32'(e_branch(1'b0)));
        adv(); #1; chk("bne_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // BEQ
        op_code = 6'b000100;
        adv(); #1; chk("beq_decode", 32'(o1), 32'(e_decode()));
        adv(); #1; chk("beq_branch", 32'(o1), 32'(e_branch(1'b1)));
        adv(); #1; chk("beq_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // ORI
        op_code = 6'b001101;
        adv(); #1; chk("ori_decode", 32'(o1), 32'(e_decode()));
        adv(); #1; chk("ori_immex", 32'(o1), 32'(e_immex(3'b001, 1'b1)));
        adv(); #1; chk("ori_immwrbk", 32'(o1), 32'(e_immwrbk(3'b001, 1'b1)));
        adv(); #1; chk("ori_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // ADDI
        op_code = 6'b001000;
        adv(); adv(); #1; chk("addi_immex", 32'(o1), 32'(e_immex(3'b010, 1'b0)));
        adv(); #1; chk("addi_immwrbk", 32'(o1), 32'(e_immwrbk(3'b010, 1'b0)));
        adv(); #1; chk("addi_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // SUB
        op_code = 6'b000000; funct = 6'b100010;
        adv(); adv(); #1; chk("sub_exec", 32'(o1), 32'(e_exec(3'b110)));
        adv(); #1; chk("sub_aluwrbk", 32'(o1), 32'(e_aluwrbk()));
        adv(); #1; chk("sub_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // J
        op_code = 6'b000010;
        adv(); #1; chk("j_decode", 32'(o1), 32'(e_decode()));
        adv(); #1; chk("j_jmp", 32'(o1), 32'(e_jmp()));
        adv(); #1; chk("j_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // SW with ready on the last allowed wait cycle: access completes, no trap
        op_code = 6'b101011;
        adv(); adv(); #1; chk("sw_memadr", 32'(o1), 32'(e_memadr()));
        adv(); mem_ready = 1'b0;
        #1; chk("sw_edge_wait1", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_edge_wait2", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_edge_wait3", 32'(o1), 32'(e_memwr()));
        adv(); mem_ready = 1'b1;
        #1; chk("sw_edge_ready", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_edge_back_fetch", 32'(o1), 32'(e_fetch(1'b1)));

        // Undefined opcode: trap with illegal_op held, ignoring inputs, for 20 cycles
        op_code = 6'b111111;
        adv(); #1; chk("illop_decode", 32'(o1), 32'(e_decode()));
        for (int i = 0; i < 20; i++) begin
            adv();
            mem_ready = i[0];
            stall = i[1];
            #1; chk("illop_trap_hold", 32'(o1), 32'(e_trap(1'b1, 1'b0)));
        end
        stall = 1'b0; mem_ready = 1'b1; rst = 1'b0;
        #1; chk("illop_reset", 32'(o1), 32'(e_zero()));
        adv(); rst = 1'b1; op_code = 6'b000000; funct = 6'b111111;
        #1; chk("illop_after_reset", 32'(o1), 32'(e_fetch(1'b1)));

        // Undefined funct: EXEC then trap, no writeback
        adv(); adv(); #1; chk("badfunct_exec_state", 32'(o1.st), 32'd6);
        adv(); #1; chk("badfunct_trap", 32'(o1), 32'(e_trap(1'b1, 1'b0)));
        rst = 1'b0;
        adv(); rst = 1'b1; op_code = 6'b101011;
        #1; chk("badfunct_after_reset", 32'(o1), 32'(e_fetch(1'b1)));

        // SW with memory never ready: trap after 4 waiting cycles
        adv(); adv(); adv(); mem_ready = 1'b0;
        #1; chk("sw_tmo_wait1", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_tmo_wait2", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_tmo_wait3", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_tmo_wait4", 32'(o1), 32'(e_memwr()));
        adv(); #1; chk("sw_tmo_trap", 32'(o1), 32'(e_trap(1'b0, 1'b1)));
        adv(); #1; chk("sw_tmo_trap_hold", 32'(o1), 32'(e_trap(1'b0, 1'b1)));
        rst = 1'b0;
        #1; chk("sw_tmo_reset", 32'(o1), 32'(e_zero()));

        // Stall in FETCH for 5 cycles: no request, no PC write
        adv(); rst = 1'b1; mem_ready = 1'b1; stall = 1'b1;
        #1; chk("stall_1", 32'(o1), 32'(e_zero()));
        for (int i = 0; i < 4; i++) begin
            adv(); #1; chk("stall_hold", 32'(o1), 32'(e_zero()));
        end
        adv(); stall = 1'b0;
        #1; chk("stall_release", 32'(o1), 32'(e_fetch(1'b1)));

        // Reset asserted in MEMWR: everything low that same cycle and after
        adv(); adv(); adv(); mem_ready = 1'b0;
        #1; chk("rst_memwr_before", 32'(o1), 32'(e_memwr()));
        rst = 1'b0;
        #1; chk("rst_memwr_same_cycle", 32'(o1), 32'(e_zero()));
        adv(); #1; chk("rst_memwr_held", 32'(o1), 32'(e_zero()));
        rst = 1'b1; mem_ready = 1'b1;
        #1; chk("rst_memwr_release", 32'(o1), 32'(e_fetch(1'b1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
